reg_writeback_unit: RTL

REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

---
 rtl/kgp_risc_pkg.sv | 14 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/reg_writeback_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared kgp_risc definitions: default datapath sizes and the writeback queue record.
package kgp_risc;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DEPTH  = 4;
   localparam int CNT_W      = 3;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue with two push ports (a before b) and one pop port.
// Exposes its storage and an occupancy mask so the owner can search pending writes.
module wb_fifo
   import kgp_risc::*;
#(
   parameter int  DEPTH   = DEF_DEPTH,
   parameter type entry_t = wb_entry
) (
   input  logic             clka,
   input  logic             rst,
   input  logic             i_push_a,
   input  entry_t           i_data_a,
   input  logic             i_push_b,
   input  entry_t           i_data_b,
   input  logic             i_pop,
   output entry_t           o_head,
   output logic [CNT_W-1:0] o_count,
   output entry_t           o_mem [DEPTH],
   output logic [DEPTH-1:0] o_occ
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic [CNT_W-1:0] w_n_push;
   logic [PTR_W-1:0] w_wr_ptr_b;

   assign w_n_push   = CNT_W'(i_push_a) + CNT_W'(i_push_b);
   assign w_wr_ptr_b = r_wr_ptr + PTR_W'(1);

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clka) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
         r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
         r_count  <= r_count + w_n_push - CNT_W'(i_pop);
      end
   end

   // NOTE: storage has no reset; stale slots are masked by the pointers and count.
   always_ff @(posedge clka) begin
      if (i_push_a) r_mem[r_wr_ptr]   <= i_data_a;
      if (i_push_b) r_mem[w_wr_ptr_b] <= i_data_b;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_mem   = r_mem;

   // A slot is live when its distance from the read pointer is below the occupancy.
   for (genvar j = 0; j < DEPTH; j++) begin : g_occ
      logic [PTR_W-1:0] w_off;
      assign w_off    = PTR_W'(j) - r_rd_ptr;
      assign o_occ[j] = CNT_W'(w_off) < r_count;
   end

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and load results into an in-order writeback stream for the register file,
// with a scoreboard telling the read ports which registers still have a write in flight.
module reg_writeback_unit
   import kgp_risc::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clka,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [ADDR_W-1:0] WriteAddr,
   output logic [DATA_W-1:0] WriteData,
   output logic              reg_write,
   input  logic [ADDR_W-1:0] qaddr1,
   input  logic [ADDR_W-1:0] qaddr2,
   output logic              pending1,
   output logic              pending2,
   output logic [2:0]        count
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] SECOND_LAST = CNT_W'(DEPTH - 2);

   logic             w_alu_fire;
   logic             w_ld_fire;
   logic             w_push_a;
   logic             w_push_b;
   logic             w_pop;
   entry_t           w_data_a;
   entry_t           w_data_b;
   entry_t           w_head;
   entry_t           w_mem [DEPTH];
   logic [DEPTH-1:0] w_occ;

   // Readiness looks only at registered occupancy, so a pop in this cycle never frees a slot.
   assign alu_ready = (count <= LAST_SLOT);
   assign ld_ready  = (count <= SECOND_LAST) || ((count == LAST_SLOT) && !alu_valid);

   assign w_alu_fire = alu_valid && alu_ready;
   assign w_ld_fire  = ld_valid && ld_ready;
   assign w_push_a   = w_alu_fire || w_ld_fire;
   assign w_push_b   = w_alu_fire && w_ld_fire;
   assign w_data_a   = w_alu_fire ? entry_t'{addr: alu_addr, data: alu_data}
                                  : entry_t'{addr: ld_addr, data: ld_data};
   assign w_data_b   = entry_t'{addr: ld_addr, data: ld_data};
   assign w_pop      = (count != '0);

   wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clka     (clka),
      .rst      (rst),
      .i_push_a (w_push_a),
      .i_data_a (w_data_a),
      .i_push_b (w_push_b),
      .i_data_b (w_data_b),
      .i_pop    (w_pop),
      .o_head   (w_head),
      .o_count  (count),
      .o_mem    (w_mem),
      .o_occ    (w_occ)
   );

   always_ff @(posedge clka) begin
      if (rst) begin
         reg_write <= 1'b0;
         WriteAddr <= '0;
         WriteData <= '0;
      end else if (w_pop) begin
         reg_write <= 1'b1;
         WriteAddr <= w_head.addr;
         WriteData <= w_head.data;
      end else begin
         reg_write <= 1'b0;
      end
   end

   // NOTE: both outputs get a default first so no path through the block infers a latch.
   always_comb begin
      pending1 = reg_write && (WriteAddr == qaddr1);
      pending2 = reg_write && (WriteAddr == qaddr2);
      for (int j = 0; j < DEPTH; j++) begin
         if (w_occ[j] && (w_mem[j].addr == qaddr1)) pending1 = 1'b1;
         if (w_occ[j] && (w_mem[j].addr == qaddr2)) pending2 = 1'b1;
      end
   end

endmodule
